// File: rtl/ssv_readout.sv
// ssv_readout: streams a filtered frame out of BRAM in raster order through a 2-entry FIFO
module ssv_readout #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    output logic             rd_en,
    output logic [3:0]       rd_i,
    output logic [3:0]       rd_j,
    input  logic [PIX_W-1:0] rd_data,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nxt;
    logic done_d, start, pop, in_flight, fl_eol, fl_eof, last_col, last_pix;
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic [PIX_W+1:0] mem [2];
    assign start     = done & ~done_d & (state == IDLE);
    assign pop       = pix_valid & pix_ready;
    assign last_col  = rd_j == 4'(IMG_W - 1);
    assign last_pix  = last_col && rd_i == 4'(IMG_H - 1);
    assign pix_valid = count != 2'd0;
    assign {pix_eof, pix_eol, pix_data} = mem[rd_ptr];
    assign busy      = state != IDLE;
    // Issue a read only when the FIFO is guaranteed a free slot for its data; walk the FSM
    always_comb begin
        rd_en     = state == FETCH && (3'(count) + 3'(in_flight) - 3'(pop)) < 3'd2;
        state_nxt = start ? FETCH :
                    (rd_en && last_pix) ? DRAIN :
                    (state == DRAIN && pop && pix_eof) ? IDLE : state;
    end
    // State register and done edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_d <= done;
        end
    end
    // Raster address counter, rewound at frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_i <= '0;
            rd_j <= '0;
        end else if (start) begin
            rd_i <= '0;
            rd_j <= '0;
        end else if (rd_en) begin
            rd_j <= last_col ? 4'd0 : rd_j + 4'd1;
            rd_i <= last_pix ? 4'd0 : last_col ? rd_i + 4'd1 : rd_i;
        end
    end
    // Track the outstanding read and the row/frame flags of its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
            fl_eol    <= 1'b0;
            fl_eof    <= 1'b0;
        end else begin
            in_flight <= rd_en;
            fl_eol    <= last_col;
            fl_eof    <= last_pix;
        end
    end
    // Two-entry FIFO holding pixel data with its eol/eof flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_flight) begin
                mem[wr_ptr] <= {fl_eof, fl_eol, rd_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(in_flight) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_ssv_readout.sv
// tb_ssv_readout: directed checks of frame readout, backpressure, retrigger and reset
module tb_ssv_readout;
    localparam int IMG_W = 12, IMG_H = 12, PIX_W = 8, N = IMG_W * IMG_H;
    logic clk = 0, rst = 1, done = 0, pix_ready = 1;
    logic rd_en, pix_valid, pix_eol, pix_eof, busy;
    logic [3:0] rd_i, rd_j;
    logic [PIX_W-1:0] rd_data, pix_data;
    int checks = 0, failures = 0;
    int cyc = 0, rd_count = 0, stall_err = 0, first_cyc = 0, last_cyc = 0;
    logic busy_at_eof = 0, prev_stall = 0;
    logic [PIX_W+1:0] prev_beat = '0;
    logic [PIX_W+1:0] got [$];
    always #5 clk = ~clk;
    ssv_readout #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .done(done), .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
        .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );
    // BRAM image holds 12*i + j, one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= PIX_W'(IMG_W * rd_i + rd_j);
            rd_count <= rd_count + 1;
        end
    end
    // Capture transfers and watch stall stability, away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && prev_stall && {pix_eof, pix_eol, pix_data} != prev_beat) stall_err <= stall_err + 1;
        prev_stall <= pix_valid && !pix_ready;
        prev_beat  <= {pix_eof, pix_eol, pix_data};
        if (pix_valid && pix_ready) begin
            if (got.size() == 0) first_cyc <= cyc;
            last_cyc <= cyc;
            if (pix_eof) busy_at_eof <= busy;
            got.push_back({pix_eof, pix_eol, pix_data});
        end
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    task automatic start_frame();
        done = 0;
        @(posedge clk); #1;
        done = 1;
        got.delete();
        @(posedge clk); #1;
    endtask
    task automatic run_to_eof(input int mode, input string tag);
        int n = 0;
        while (!(got.size() > 0 && got[$][PIX_W+1]) && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1) pix_ready = ~pix_ready;
            if (mode == 3 && got.size() == 50) done = 0;
            else if (mode == 3 && got.size() > 50) done = 1;
        end
        check({tag, " eof timeout"}, n < 2000, 1);
    endtask
    task automatic check_frame(input string tag);
        int err = 0;
        for (int k = 0; k < got.size(); k++)
            if (got[k] !== {1'(k == N - 1), 1'(k % IMG_W == IMG_W - 1), PIX_W'(k)}) err++;
        check({tag, " count"}, got.size(), N);
        check({tag, " order"}, err, 0);
    endtask
    initial begin
        int n, rd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outs", {rd_en, rd_i, rd_j, pix_valid, pix_data, pix_eol, pix_eof, busy}, 0);
        rst = 0;
        @(posedge clk); #1;
        check("idle busy", busy, 0);
        start_frame();
        check("A rd_en", rd_en, 1);
        check("A addr", {rd_i, rd_j}, 0);
        check("A busy", busy, 1);
        check("A valid c1", pix_valid, 0);
        @(posedge clk); #1;
        check("A valid c2", pix_valid, 0);
        @(posedge clk); #1;
        check("A valid c3", pix_valid, 1);
        check("A first data", pix_data, 0);
        run_to_eof(0, "A");
        check("A busy at eof", busy_at_eof, 1);
        check("A busy after eof", busy, 0);
        check_frame("A");
        check("A no bubbles", last_cyc - first_cyc, N - 1);
        rd0 = rd_count;
        repeat (10) @(posedge clk);
        #1;
        check("E held done busy", busy, 0);
        check("E held done reads", rd_count - rd0, 0);
        start_frame();
        run_to_eof(1, "B");
        pix_ready = 1;
        check_frame("B");
        check("B stall stable", stall_err, 0);
        pix_ready = 0;
        rd0 = rd_count;
        start_frame();
        repeat (19) @(posedge clk);
        #1;
        check("C reads issued", rd_count - rd0, 2);
        check("C valid held", pix_valid, 1);
        check("C data held", pix_data, 0);
        pix_ready = 1;
        run_to_eof(0, "C");
        check_frame("C");
        start_frame();
        run_to_eof(3, "D");
        check_frame("D");
        repeat (5) @(posedge clk);
        #1;
        check("D no refire", busy, 0);
        check("D no extra pixels", got.size(), N);
        start_frame();
        n = 0;
        while (got.size() < 70 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("F reach 70", n < 1000, 1);
        done = 0;
        rst = 1;
        #1;
        check("F rst outs", {rd_en, rd_i, rd_j, pix_valid, pix_data, pix_eol, pix_eof, busy}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("F idle after rst", busy, 0);
        start_frame();
        check("F restart addr", {rd_i, rd_j}, 0);
        run_to_eof(0, "F");
        check_frame("F");
        check("stall stable all", stall_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
